// File: rtl/tick_sched_pkg.sv
// Shared definitions for the tick scheduler: divider derivation and channel state encoding.
package tick_sched_pkg;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_FIRE = 2'd2
  } ch_state_e;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // ceil(log2(div)), never below 1 so the prescaler always has at least one bit
  function automatic int presc_width(input int div);
    int w;
    w = 1;
    while ((64'd1 << w) < 64'(div)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// One countdown channel: loads a duration in ms, counts shared ticks, pulses done on expiry.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int DUR_W = 16
) (
  input  logic             clk_12mhz,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             cancel,
  input  logic [DUR_W-1:0] duration,
  output logic             busy,
  output logic             done
);

  ch_state_e        state_q;
  logic [DUR_W-1:0] remaining_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;

  // Cancel only wins while counting; in IDLE and FIRE a start is always taken.
  assign accept = start && ((state_q != CH_RUN) || !cancel);

  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CH_IDLE;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        remaining_q <= duration;
        if (duration == '0) begin
          state_q <= CH_FIRE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= CH_RUN;
          busy_q  <= 1'b1;
        end
      end else if (state_q == CH_RUN) begin
        if (cancel) begin
          state_q     <= CH_IDLE;
          busy_q      <= 1'b0;
          remaining_q <= '0;
        end else if (tick) begin
          if (remaining_q == DUR_W'(1)) begin
            state_q     <= CH_FIRE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            remaining_q <= '0;
          end else begin
            remaining_q <= remaining_q - 1'b1;
          end
        end
      end else begin
        state_q <= CH_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: rtl/tick_scheduler.sv
// Shared 1 ms prescaler feeding N_CH independent countdown channels, all on clk_12mhz.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1000,
  parameter int N_CH    = 4,
  parameter int DUR_W   = 16
) (
  input  logic                  clk_12mhz,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       cancel,
  input  logic [N_CH*DUR_W-1:0] duration,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic                  tick_1ms
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          tick_q;

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

  // tick is registered from the next count so it is high exactly while cnt_q == DIV-1
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_1ms = tick_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    tick_channel #(
      .DUR_W(DUR_W)
    ) u_ch (
      .clk_12mhz(clk_12mhz),
      .rst_n    (rst_n),
      .tick     (tick_q),
      .start    (start[gi]),
      .cancel   (cancel[gi]),
      .duration (duration[gi*DUR_W +: DUR_W]),
      .busy     (busy[gi]),
      .done     (done[gi])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with a scaled-down divider (DIV = 12) to keep runs short.
module tb_tick_scheduler;

  localparam int CLK_HZ  = 12000;
  localparam int TICK_HZ = 1000;
  localparam int N_CH    = 4;
  localparam int DUR_W   = 16;

  logic                  clk_12mhz;
  logic                  rst_n;
  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       cancel;
  logic [N_CH*DUR_W-1:0] duration;
  logic [N_CH-1:0]       busy;
  logic [N_CH-1:0]       done;
  logic                  tick_1ms;

  int tests;
  int failed;
  int n;
  logic [3:0] ev_b;
  logic [3:0] ev_d;

  tick_scheduler #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .N_CH   (N_CH),
    .DUR_W  (DUR_W)
  ) dut (
    .clk_12mhz(clk_12mhz),
    .rst_n    (rst_n),
    .start    (start),
    .cancel   (cancel),
    .duration (duration),
    .busy     (busy),
    .done     (done),
    .tick_1ms (tick_1ms)
  );

  initial clk_12mhz = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  // Rising edges since reset release; cycle n is the one in which the prescaler count equals n mod 12.
  always @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at n=%0d", n);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic step_to(input int target);
    while (n < target) @(negedge clk_12mhz);
  endtask

  task automatic set_dur(input int ch, input int val);
    duration[ch*DUR_W +: DUR_W] = DUR_W'(val);
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst_n    = 1'b0;
    start    = '0;
    cancel   = '0;
    duration = '0;

    repeat (3) @(negedge clk_12mhz);
    check("rst_tick", 32'(tick_1ms), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    rst_n = 1'b1;

    // Free-running prescaler with no requests
    for (int k = 1; k <= 36; k++) begin
      step_to(k);
      check("t1_tick", 32'(tick_1ms), 32'(k % 12 == 11));
      check("t1_busy", 32'(busy), 32'(0));
      check("t1_done", 32'(done), 32'(0));
    end

    // ch0, D=3 accepted in the cycle after the tick at 47
    step_to(48);
    start[0] = 1'b1; set_dur(0, 3);
    step_to(49);
    start = '0;
    for (int k = 49; k <= 86; k++) begin
      step_to(k);
      check("t2_busy", 32'(busy), (k <= 83) ? 32'h1 : 32'h0);
      check("t2_done", 32'(done), (k == 84) ? 32'h1 : 32'h0);
    end

    // ch1, D=0: done the next cycle, never busy
    step_to(90);
    start[1] = 1'b1; set_dur(1, 0);
    step_to(91);
    start = '0;
    check("t3_done", 32'(done), 32'h2);
    check("t3_busy", 32'(busy), 32'h0);
    step_to(92);
    check("t3_done_end", 32'(done), 32'h0);
    check("t3_busy_end", 32'(busy), 32'h0);

    // Start plus cancel during FIRE: done completes, new start taken, cancel ignored
    step_to(94);
    start[1] = 1'b1; set_dur(1, 0);
    step_to(95);
    check("t3b_fire", 32'(done), 32'h2);
    check("t3b_tick", 32'(tick_1ms), 32'h1);
    start[1] = 1'b1; cancel[1] = 1'b1; set_dur(1, 2);
    step_to(96);
    start = '0; cancel = '0;
    for (int k = 96; k <= 122; k++) begin
      step_to(k);
      check("t3b_busy", 32'(busy), (k < 120) ? 32'h2 : 32'h0);
      check("t3b_done", 32'(done), (k == 120) ? 32'h2 : 32'h0);
    end

    // ch2, D=5, cancelled after two ticks
    step_to(124);
    start[2] = 1'b1; set_dur(2, 5);
    step_to(125);
    start = '0;
    check("t4_busy", 32'(busy), 32'h4);
    step_to(144);
    check("t4_busy_pre", 32'(busy), 32'h4);
    cancel[2] = 1'b1;
    step_to(145);
    cancel = '0;
    for (int k = 145; k <= 185; k++) begin
      step_to(k);
      check("t4_busy_cx", 32'(busy), 32'h0);
      check("t4_done_cx", 32'(done), 32'h0);
    end
    step_to(186);
    start[2] = 1'b1; set_dur(2, 5);
    step_to(187);
    start = '0;
    check("t4_rerun", 32'(busy), 32'h4);
    step_to(188);
    start[2] = 1'b1; cancel[2] = 1'b1; set_dur(2, 7);
    step_to(189);
    start = '0; cancel = '0;
    check("t4_sc_busy", 32'(busy), 32'h0);
    check("t4_sc_done", 32'(done), 32'h0);
    step_to(190);
    check("t4_sc_busy2", 32'(busy), 32'h0);

    // All channels start in a tick cycle; that tick is not counted
    step_to(191);
    check("t5_tick", 32'(tick_1ms), 32'h1);
    start = 4'hF;
    for (int i = 0; i < 4; i++) set_dur(i, i + 1);
    step_to(192);
    start = '0;
    for (int k = 192; k <= 245; k++) begin
      step_to(k);
      for (int i = 0; i < 4; i++) begin
        ev_b[i] = (k < 204 + 12 * i);
        ev_d[i] = (k == 204 + 12 * i);
      end
      check("t5_busy", 32'(busy), 32'(ev_b));
      check("t5_done", 32'(done), 32'(ev_d));
    end

    // ch3, D=4 retriggered with D=2 after three ticks
    step_to(248);
    start[3] = 1'b1; set_dur(3, 4);
    step_to(249);
    start = '0;
    step_to(276);
    check("t6_busy_pre", 32'(busy), 32'h8);
    start[3] = 1'b1; set_dur(3, 2);
    step_to(277);
    start = '0;
    for (int k = 277; k <= 302; k++) begin
      step_to(k);
      check("t6_busy", 32'(busy), (k < 300) ? 32'h8 : 32'h0);
      check("t6_done", 32'(done), (k == 300) ? 32'h8 : 32'h0);
    end

    // ch3 running, asynchronous reset while tick_1ms is high
    step_to(312);
    start[3] = 1'b1; set_dur(3, 4);
    step_to(313);
    start = '0;
    step_to(335);
    check("t7_tick_pre", 32'(tick_1ms), 32'h1);
    check("t7_busy_pre", 32'(busy), 32'h8);
    rst_n = 1'b0;
    #1;
    check("t7_async_tick", 32'(tick_1ms), 32'h0);
    check("t7_async_busy", 32'(busy), 32'h0);
    check("t7_async_done", 32'(done), 32'h0);
    repeat (3) @(negedge clk_12mhz);
    check("t7_hold_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step_to(k);
      check("t7_tick", 32'(tick_1ms), 32'(k % 12 == 11));
      check("t7_busy", 32'(busy), 32'h0);
      check("t7_done", 32'(done), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
